// File: rtl/piso_shift_ctrl_if.sv
// Bundle of handshake, PISO pin and frame-strobe signals for piso_shift_ctrl.
// master: word producer / link side; slave: the controller.
interface piso_shift_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             piso_load;
    logic [WIDTH-1:0] piso_pi;
    logic             piso_si;
    logic             ser_valid;
    logic             ser_first;
    logic             ser_last;
    logic             busy;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  piso_load,
        input  piso_pi,
        input  piso_si,
        input  ser_valid,
        input  ser_first,
        input  ser_last,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output piso_load,
        output piso_pi,
        output piso_si,
        output ser_valid,
        output ser_first,
        output ser_last,
        output busy
    );
endinterface

// File: rtl/piso_shift_ctrl.sv
// Sequencer for an external free-running PISO shift register (MSB first).
// Loads words accepted over valid/ready, then flags the WIDTH cycles in which
// the PISO serial output carries data, with optional idle gap between words.
module piso_shift_ctrl #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned GAP     = 0,
    parameter logic        SI_FILL = 1'b0
) (
    input logic              CLK,
    input logic              RESET,
    piso_shift_ctrl_if.slave bus
);
    localparam int unsigned     CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [3:0]      GAP_LD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam bit              NO_GAP = (GAP == 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       gcnt_q, gcnt_d;
    logic             last_bit;
    logic             ready;
    logic             accept;

    assign last_bit = (cnt_q == CNT_LAST);

    // Handshake: ready in IDLE, or on the final bit for zero-gap back-to-back words.
    always_comb begin
        ready  = 1'b0;
        accept = 1'b0;
        if (!RESET) begin
            ready = (state_q == S_IDLE) ||
                    ((state_q == S_SHIFT) && last_bit && NO_GAP);
        end
        accept = bus.in_valid && ready;
    end

    // Next-state logic for the word/gap sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                end
            end
            S_SHIFT: begin
                if (!last_bit) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (NO_GAP) begin
                    if (accept) begin
                        cnt_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_GAP;
                    gcnt_d  = GAP_LD;
                end
            end
            S_GAP: begin
                if (gcnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    gcnt_d = gcnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset drops any word in flight.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
        end
    end

    // Strobes decode registered state only; RESET masks them in the reset cycle.
    always_comb begin
        bus.ser_valid = 1'b0;
        bus.ser_first = 1'b0;
        bus.ser_last  = 1'b0;
        bus.busy      = 1'b0;
        if (!RESET) begin
            bus.ser_valid = (state_q == S_SHIFT);
            bus.ser_first = (state_q == S_SHIFT) && (cnt_q == '0);
            bus.ser_last  = (state_q == S_SHIFT) && last_bit;
            bus.busy      = (state_q != S_IDLE);
        end
    end

    assign bus.in_ready  = ready;
    assign bus.piso_load = accept;
    assign bus.piso_pi   = bus.in_data;
    assign bus.piso_si   = SI_FILL;
endmodule
